// File: rtl/conv_pkg.sv
// conv_pkg: shared types, widths and helpers for the 3x3 convolution engine.
//   TAPS   - window taps per output pixel
//   PIX_W  - pixel width (unsigned)
//   COEF_W - kernel coefficient width (two's complement)
//   ACC_W  - accumulator width (signed; cannot overflow for 9 products)
//   conv_state_t - sequencer states
//   sat_u8 - arithmetic shift followed by saturation to 0..255
package conv_pkg;

  localparam int TAPS   = 9;
  localparam int PIX_W  = 8;
  localparam int COEF_W = 8;
  localparam int ACC_W  = 24;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    ACC,
    WRITE,
    DONE
  } conv_state_t;

  function automatic logic [PIX_W-1:0] sat_u8(input logic signed [ACC_W-1:0] acc,
                                              input int unsigned shift);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> shift;
    if (sh[ACC_W-1])
      return '0;
    else if (sh > ACC_W'(255))
      return '1;
    else
      return sh[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/conv_mac.sv
// conv_mac: signed multiply-accumulate for one output pixel.
//   clk, rst - clock and synchronous active-high reset
//   clear    - zero the accumulator (wins over acc_en)
//   acc_en   - add pix * coef into the accumulator
//   pix      - unsigned pixel
//   coef     - signed coefficient
//   result   - saturated 8-bit value of the accumulator as it will be
//              after this cycle's update
module conv_mac
  import conv_pkg::*;
#(
  parameter int unsigned SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     acc_en,
  input  logic [PIX_W-1:0]         pix,
  input  logic signed [COEF_W-1:0] coef,
  output logic [PIX_W-1:0]         result
);

  logic signed [PIX_W+COEF_W:0] prod;
  logic signed [ACC_W-1:0]      acc;
  logic signed [ACC_W-1:0]      acc_d;

  assign prod = $signed({1'b0, pix}) * coef;

  always_comb begin
    acc_d = acc;
    if (clear)
      acc_d = '0;
    else if (acc_en)
      acc_d = acc + {{(ACC_W-PIX_W-COEF_W-1){prod[PIX_W+COEF_W]}}, prod};
  end

  always_ff @(posedge clk) begin
    if (rst)
      acc <= '0;
    else
      acc <= acc_d;
  end

  // Exposing the next value lets the sequencer register the write data at the
  // same edge that folds in the final tap, keeping WRITE one cycle after ACC.
  assign result = sat_u8(acc_d, SHIFT);

endmodule

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: walks every valid 3x3 window of a row-major 8-bit
// image in RAM, multiply-accumulates against a latched signed kernel and
// writes the shifted, clamped result to a contiguous destination region.
//   clk, rst    - clock and synchronous active-high reset
//   start       - begin a run (honoured only in IDLE)
//   kernel      - K0..K8 signed bytes, K0 in [7:0]
//   busy, done  - run in progress / one-cycle completion pulse
//   ram_addr    - shared read/write address
//   ram_rd_en   - read strobe; ram_rd_data is valid the following cycle
//   ram_rd_data - returned pixel
//   ram_wr_en   - write strobe, ram_wr_data - result pixel
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W    = 16,
  parameter int unsigned IMG_H    = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned SRC_BASE = 0,
  parameter int unsigned DST_BASE = 256,
  parameter int unsigned SHIFT    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [TAPS*COEF_W-1:0]   kernel,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic                     ram_rd_en,
  input  logic [PIX_W-1:0]         ram_rd_data,
  output logic                     ram_wr_en,
  output logic [PIX_W-1:0]         ram_wr_data
);

  conv_state_t              state;
  logic [TAPS*COEF_W-1:0]   kernel_q;
  logic [3:0]               tap;
  logic [1:0]               kx;
  logic [ADDR_W-1:0]        row_off;
  logic [ADDR_W-1:0]        win_base;
  logic [ADDR_W-1:0]        win_base_nxt;
  logic [ADDR_W-1:0]        dst_ptr;
  logic [15:0]              row;
  logic [15:0]              col;
  logic                     row_end;
  logic                     last_pix;
  // Read data lags its strobe by one cycle, so the tap index is delayed too.
  logic                     pend;
  logic [3:0]               pend_tap;
  logic                     mac_clear;
  logic [PIX_W-1:0]         mac_result;

  assign row_end      = (col == 16'(IMG_W - 3));
  assign last_pix     = row_end && (row == 16'(IMG_H - 3));
  // Stepping past the last column skips the two border columns as well.
  assign win_base_nxt = win_base + (row_end ? ADDR_W'(3) : ADDR_W'(1));
  assign mac_clear    = (state == WRITE) || ((state == IDLE) && start);

  conv_mac #(.SHIFT(SHIFT)) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (mac_clear),
    .acc_en (pend),
    .pix    (ram_rd_data),
    .coef   (kernel_q[8*pend_tap +: 8]),
    .result (mac_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      ram_addr    <= '0;
      ram_rd_en   <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_wr_data <= '0;
      kernel_q    <= '0;
      tap         <= '0;
      kx          <= '0;
      row_off     <= '0;
      win_base    <= '0;
      dst_ptr     <= '0;
      row         <= '0;
      col         <= '0;
      pend        <= 1'b0;
      pend_tap    <= '0;
    end else begin
      pend     <= (state == READ);
      pend_tap <= tap;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            kernel_q  <= kernel;
            tap       <= '0;
            kx        <= '0;
            row_off   <= '0;
            row       <= '0;
            col       <= '0;
            win_base  <= ADDR_W'(SRC_BASE);
            dst_ptr   <= ADDR_W'(DST_BASE);
            ram_addr  <= ADDR_W'(SRC_BASE);
            ram_rd_en <= 1'b1;
            busy      <= 1'b1;
            state     <= READ;
          end
        end
        READ: begin
          if (tap == 4'(TAPS - 1)) begin
            ram_rd_en <= 1'b0;
            state     <= ACC;
          end else begin
            tap <= tap + 4'd1;
            if (kx == 2'd2) begin
              kx       <= '0;
              row_off  <= row_off + ADDR_W'(IMG_W);
              ram_addr <= win_base + row_off + ADDR_W'(IMG_W);
            end else begin
              kx       <= kx + 2'd1;
              ram_addr <= win_base + row_off + ADDR_W'(kx) + ADDR_W'(1);
            end
          end
        end
        ACC: begin
          ram_wr_en   <= 1'b1;
          ram_addr    <= dst_ptr;
          ram_wr_data <= mac_result;
          state       <= WRITE;
        end
        WRITE: begin
          ram_wr_en <= 1'b0;
          dst_ptr   <= dst_ptr + ADDR_W'(1);
          win_base  <= win_base_nxt;
          tap       <= '0;
          kx        <= '0;
          row_off   <= '0;
          if (row_end) begin
            col <= '0;
            row <= row + 16'd1;
          end else begin
            col <= col + 16'd1;
          end
          if (last_pix) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            ram_rd_en <= 1'b1;
            ram_addr  <= win_base_nxt;
            state     <= READ;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Testbench for conv_window_sequencer on a 4x4 image. Two instances share the
// stimulus: one with SHIFT=0 and one with SHIFT=3.
module tb_conv_window_sequencer;

  localparam int W = 4;
  localparam int H = 4;
  localparam int NOUT = (W - 2) * (H - 2);
  localparam int DST = 256;
  localparam int DONE_CYC = 1 + 11 * NOUT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [71:0] kernel = '0;

  logic        busy_a, done_a, rd_a, wr_a;
  logic [15:0] addr_a;
  logic [7:0]  rdd_a = '0, wd_a;
  logic        busy_b, done_b, rd_b, wr_b;
  logic [15:0] addr_b;
  logic [7:0]  rdd_b = '0, wd_b;

  int img[16];
  int compared = 0;
  int mismatched = 0;
  int dcyc, dcnt, bad;
  int wa[$];
  int wd0[$];
  int wd3[$];

  always #5 clk = ~clk;

  conv_window_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(16), .SRC_BASE(0),
                          .DST_BASE(DST), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .start(start), .kernel(kernel),
    .busy(busy_a), .done(done_a), .ram_addr(addr_a), .ram_rd_en(rd_a),
    .ram_rd_data(rdd_a), .ram_wr_en(wr_a), .ram_wr_data(wd_a));

  conv_window_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(16), .SRC_BASE(0),
                          .DST_BASE(DST), .SHIFT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .kernel(kernel),
    .busy(busy_b), .done(done_b), .ram_addr(addr_b), .ram_rd_en(rd_b),
    .ram_rd_data(rdd_b), .ram_wr_en(wr_b), .ram_wr_data(wd_b));

  // RAM: source image at 0..15, anything else reads as zero.
  always @(posedge clk) begin
    rdd_a <= (rd_a && addr_a < 16) ? 8'(img[addr_a[3:0]]) : 8'h00;
    rdd_b <= (rd_b && addr_b < 16) ? 8'(img[addr_b[3:0]]) : 8'h00;
  end

  typedef struct {
    string       name;
    logic [71:0] k;
    int          mode;   // 0 ramp 4r+c, 1 constant 200
    logic [31:0] e0;     // expected outputs, SHIFT=0, output i in byte i
    logic [31:0] e3;     // expected outputs, SHIFT=3
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load_image(input int mode);
    for (int i = 0; i < 16; i++) begin
      case (mode)
        0: img[i] = i;
        1: img[i] = 200;
        default: img[i] = int'($urandom_range(0, 255));
      endcase
    end
  endtask

  // Reference: direct 3x3 sum over the image, arithmetic shift, clamp.
  function automatic int model(input int r, input int c, input logic [71:0] k, input int sh);
    int s;
    logic signed [7:0] kc;
    s = 0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++) begin
        kc = k[8*(3*ky+kx) +: 8];
        s += img[(r + ky) * W + c + kx] * int'(kc);
      end
    s = s >>> sh;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  task automatic run(input logic [71:0] k, input int mid_start, input int rst_at);
    wa.delete(); wd0.delete(); wd3.delete();
    dcyc = -1; dcnt = 0; bad = 0;
    @(negedge clk);
    kernel = k;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int t = 1; t <= 60; t++) begin
      @(negedge clk);
      if (t == 1) begin
        chk("busy_cycle1", busy_a, 1);
        chk("rd_en_cycle1", rd_a, 1);
        chk("addr_cycle1", addr_a, 0);
      end
      if (dcyc > 0 && t == dcyc + 1) chk("busy_after_done", busy_a, 0);
      if (rst_at > 0 && t == rst_at + 1) begin
        chk("rst_busy", busy_a, 0);
        chk("rst_rd_en", rd_a, 0);
        chk("rst_wr_en", wr_a, 0);
        chk("rst_done", done_a, 0);
        rst = 1'b0;
      end
      if (rd_a && wr_a) bad++;
      if (rd_a && addr_a >= 16) bad++;
      if (wr_a && (addr_a < DST || addr_a >= DST + NOUT)) bad++;
      if (rd_b != rd_a || wr_b != wr_a || done_b != done_a || busy_b != busy_a ||
          addr_b != addr_a) bad++;
      if (wr_a) begin
        wa.push_back(int'(addr_a));
        wd0.push_back(int'(wd_a));
        wd3.push_back(int'(wd_b));
      end
      if (done_a) begin
        dcnt++;
        if (dcyc < 0) dcyc = t;
      end
      if (mid_start != 0) begin
        if (t == 5) start = 1'b1;
        if (t == 6) start = 1'b0;
        if (t == 20) kernel = ~kernel;
      end
      if (rst_at > 0 && t == rst_at) rst = 1'b1;
    end
  endtask

  task automatic check_run(input string nm, input logic [31:0] e0, input logic [31:0] e3);
    logic [31:0] x0, x3;
    x0 = e0;
    x3 = e3;
    chk({nm, "_nwrites"}, wa.size(), NOUT);
    chk({nm, "_done_cycle"}, dcyc, DONE_CYC);
    chk({nm, "_done_count"}, dcnt, 1);
    chk({nm, "_protocol"}, bad, 0);
    for (int i = 0; i < NOUT && i < wa.size(); i++) begin
      chk({nm, "_addr"}, wa[i], DST + i);
      chk({nm, "_data_sh0"}, wd0[i], x0[8*i +: 8]);
      chk({nm, "_data_sh3"}, wd3[i], x3[8*i +: 8]);
    end
  endtask

  vec_t vecs[4];
  logic [71:0] k_id;

  initial begin
    k_id = 72'h01 << 32;
    vecs[0] = '{"identity",   k_id,           0, {8'd10, 8'd9, 8'd6, 8'd5},        {8'd1, 8'd1, 8'd0, 8'd0}};
    vecs[1] = '{"all_ones",   {9{8'h01}},     0, {8'd90, 8'd81, 8'd54, 8'd45},     {8'd11, 8'd10, 8'd6, 8'd5}};
    vecs[2] = '{"saturate",   {9{8'h01}},     1, {4{8'd255}},                      {4{8'd225}}};
    vecs[3] = '{"neg_clamp",  72'hFF << 32,   0, 32'd0,                            32'd0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_rd_en", rd_a, 0);
    chk("reset_wr_en", wr_a, 0);
    chk("reset_addr", addr_a, 0);
    chk("reset_wr_data", wd_a, 0);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      load_image(vecs[v].mode);
      run(vecs[v].k, 0, 0);
      check_run(vecs[v].name, vecs[v].e0, vecs[v].e3);
    end

    for (int n = 0; n < 6; n++) begin
      logic [71:0] kr;
      logic [31:0] m0, m3;
      load_image(2);
      kr = {8'($urandom), 32'($urandom), 32'($urandom)};
      for (int i = 0; i < NOUT; i++) begin
        m0[8*i +: 8] = 8'(model(i / (W - 2), i % (W - 2), kr, 0));
        m3[8*i +: 8] = 8'(model(i / (W - 2), i % (W - 2), kr, 3));
      end
      run(kr, 0, 0);
      check_run("random", m0, m3);
    end

    // start pulsed mid-run and kernel changed mid-run: no effect
    load_image(0);
    run(k_id, 1, 0);
    check_run("start_mid_run", vecs[0].e0, vecs[0].e3);

    // reset during the second pixel's READ, then a clean restart
    run(k_id, 0, 14);
    chk("rst_mid_nwrites", wa.size(), 1);
    chk("rst_mid_done_count", dcnt, 0);
    chk("rst_mid_protocol", bad, 0);
    run(k_id, 0, 0);
    check_run("after_reset", vecs[0].e0, vecs[0].e3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
